// File: rtl/acorn_encrypt128.sv
// acorn_encrypt128
//   ACORN-128 associated-data and plaintext absorption stage. Takes the state
//   produced by initialization, absorbs AD bytes and their padding, then
//   encrypts PT bytes and absorbs the PT padding. The resulting state goes to
//   finalization on state_out, flagged by a one-cycle done pulse. Bytes are
//   processed bit-serially, LSB first, with one StateUpdate128 step per clock.
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start               request; samples state_in/ad_len/pt_len while idle
//   state_in [292:0]    state after initialization
//   ad_len, pt_len      byte counts (zero allowed)
//   in_valid/in_ready   AD byte stream followed by PT byte stream on in_data
//   ct_valid/ct_ready   ciphertext byte stream on ct_data
//   busy                high from accepted start through the done cycle
//   done                one-cycle pulse; state_out valid from this cycle
//   state_out [292:0]   final state, held until the next accepted start
//
// state     | meaning
// S_IDLE    | waiting for start
// S_AD_DATA | absorbing AD bytes (ca=1, cb=1)
// S_AD_PAD  | AD padding steps
// S_PT_DATA | encrypting PT bytes (ca=1, cb=0)
// S_PT_PAD  | PT padding steps
// S_DONE    | state_out presented, done pulse
module acorn_encrypt128 #(
  parameter int LEN_W   = 16,
  parameter int PAD_LEN = 256,
  parameter int CA_PAD  = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [292:0]     state_in,
  input  logic [LEN_W-1:0] ad_len,
  input  logic [LEN_W-1:0] pt_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  output logic             ct_valid,
  input  logic             ct_ready,
  output logic [7:0]       ct_data,
  output logic             busy,
  output logic             done,
  output logic [292:0]     state_out
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_AD_DATA = 3'd1;
  localparam logic [2:0] S_AD_PAD  = 3'd2;
  localparam logic [2:0] S_PT_DATA = 3'd3;
  localparam logic [2:0] S_PT_PAD  = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  // One spare bit so PAD_LEN itself would still be representable.
  localparam int PAD_W = $clog2(PAD_LEN + 1);

  logic [2:0]       fsm;
  logic [292:0]     st;
  logic [LEN_W-1:0] len_ad;
  logic [LEN_W-1:0] len_pt;
  logic [LEN_W-1:0] byte_cnt;
  logic [PAD_W-1:0] pad_j;
  logic [2:0]       bit_idx;
  logic             have_byte;
  logic [7:0]       sh;
  logic [7:0]       ct_acc;

  logic             is_data;
  logic             is_pad;
  logic             step_en;
  logic             pad_last;
  logic [LEN_W-1:0] cur_len;
  logic             m_bit;
  logic             ca_bit;
  logic             cb_bit;
  logic [292:0]     s1;
  logic             ks;
  logic             fbk;
  logic [292:0]     st_next;
  logic             ct_bit;

  assign is_data  = (fsm == S_AD_DATA) || (fsm == S_PT_DATA);
  assign is_pad   = (fsm == S_AD_PAD) || (fsm == S_PT_PAD);
  assign step_en  = is_pad || (is_data && have_byte);
  assign pad_last = (pad_j == PAD_W'(PAD_LEN - 1));
  assign cur_len  = (fsm == S_PT_DATA) ? len_pt : len_ad;
  assign busy     = (fsm != S_IDLE);

  // A pending ciphertext byte that is being taken this cycle does not block
  // the next plaintext byte, so the two handshakes can overlap.
  assign in_ready = is_data && !have_byte && (!ct_valid || ct_ready) &&
                    (byte_cnt != cur_len);

  always_comb begin
    m_bit  = sh[0];
    ca_bit = 1'b1;
    if (is_pad) begin
      m_bit  = (pad_j == '0);
      ca_bit = (pad_j < PAD_W'(CA_PAD));
    end
    cb_bit = (fsm == S_AD_DATA) || (fsm == S_AD_PAD);
  end

  // StateUpdate128: the six LFSR feedbacks all read pre-update bits, then the
  // keystream and nonlinear feedback read the LFSR-updated state.
  always_comb begin
    s1      = st;
    s1[289] = st[289] ^ st[235] ^ st[230];
    s1[230] = st[230] ^ st[196] ^ st[193];
    s1[193] = st[193] ^ st[160] ^ st[154];
    s1[154] = st[154] ^ st[111] ^ st[107];
    s1[107] = st[107] ^ st[66]  ^ st[61];
    s1[61]  = st[61]  ^ st[23]  ^ st[0];
    ks  = s1[12] ^ s1[154]
        ^ ((s1[235] & s1[61]) ^ (s1[235] & s1[193]) ^ (s1[61] & s1[193]))
        ^ ((s1[230] & s1[111]) ^ (~s1[230] & s1[66]));
    fbk = s1[0] ^ ~s1[107]
        ^ ((s1[244] & s1[23]) ^ (s1[244] & s1[160]) ^ (s1[23] & s1[160]))
        ^ (ca_bit & s1[196]) ^ (cb_bit & ks);
    st_next = {fbk ^ m_bit, s1[292:1]};
  end

  assign ct_bit = sh[0] ^ ks;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm       <= S_IDLE;
      st        <= '0;
      len_ad    <= '0;
      len_pt    <= '0;
      byte_cnt  <= '0;
      pad_j     <= '0;
      bit_idx   <= '0;
      have_byte <= 1'b0;
      sh        <= '0;
      ct_acc    <= '0;
      ct_valid  <= 1'b0;
      ct_data   <= '0;
      done      <= 1'b0;
      state_out <= '0;
    end else begin
      done <= 1'b0;
      if (step_en) st <= st_next;
      if (ct_valid && ct_ready) ct_valid <= 1'b0;

      case (fsm)
        S_IDLE: begin
          if (start) begin
            st        <= state_in;
            len_ad    <= ad_len;
            len_pt    <= pt_len;
            byte_cnt  <= '0;
            pad_j     <= '0;
            bit_idx   <= '0;
            have_byte <= 1'b0;
            fsm       <= (ad_len != '0) ? S_AD_DATA : S_AD_PAD;
          end
        end

        S_AD_DATA, S_PT_DATA: begin
          if (in_valid && in_ready) begin
            have_byte <= 1'b1;
            sh        <= in_data;
            bit_idx   <= '0;
          end else if (have_byte) begin
            sh      <= sh >> 1;
            ct_acc  <= {ct_bit, ct_acc[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              have_byte <= 1'b0;
              byte_cnt  <= byte_cnt + LEN_W'(1);
              if (fsm == S_PT_DATA) begin
                ct_data  <= {ct_bit, ct_acc[7:1]};
                ct_valid <= 1'b1;
              end else if (byte_cnt + LEN_W'(1) == len_ad) begin
                fsm   <= S_AD_PAD;
                pad_j <= '0;
              end
            end
          end else if (fsm == S_PT_DATA && byte_cnt == len_pt &&
                       ct_valid && ct_ready) begin
            // Leave only once the last ciphertext byte has been taken.
            fsm   <= S_PT_PAD;
            pad_j <= '0;
          end
        end

        S_AD_PAD: begin
          pad_j <= pad_j + PAD_W'(1);
          if (pad_last) begin
            pad_j    <= '0;
            byte_cnt <= '0;
            fsm      <= (len_pt != '0) ? S_PT_DATA : S_PT_PAD;
          end
        end

        S_PT_PAD: begin
          pad_j <= pad_j + PAD_W'(1);
          if (pad_last) begin
            pad_j     <= '0;
            fsm       <= S_DONE;
            done      <= 1'b1;
            state_out <= st_next;
          end
        end

        S_DONE: fsm <= S_IDLE;

        default: fsm <= S_IDLE;
      endcase
    end
  end

endmodule
